fwd_operand_select: RTL and testbench
=====================================

// Module: fwd_operand_select
// PURPOSE
//  Parametrised N-input, multi-channel operand selector with a registered output stage.
//  Sits at the ID/EX boundary. Each channel (rs, rt, ...) independently picks one of NUM_IN
//  candidate values: register file, EX/MEM forward, MEM/WB forward, immediate, ...
//  Adds pipeline stall/flush handling, valid tracking, out-of-range select detection and a
//  stall-duration counter. None of these exist in the fixed 4:1 combinational selector.
// PARAMETERS
//  DATA_W      32             width of each candidate and each output channel
//  NUM_IN      4              candidate inputs per channel; legal range 2..16
//  NUM_CH      2              independent output channels
//  SEL_W       $clog2(NUM_IN) select width per channel (localparam, not overridable)
//  DEFAULT_VAL 32'h0000_0000  value driven when a select is out of range (resized to DATA_W)
//  HOLD_CNT_W  8              width of the saturating stall counter
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               synchronous, active-high reset
//  in_valid   in   1               candidates and selects are valid this cycle
//  stall      in   1               hazard unit: hold the output register
//  flush      in   1               hazard unit: insert a bubble
//  data_in    in   NUM_IN*DATA_W   candidate k occupies bits [k*DATA_W +: DATA_W]
//  sel        in   NUM_CH*SEL_W    channel c select occupies [c*SEL_W +: SEL_W]
//  err_clr    in   1               clears sel_err
//  out_data   out  NUM_CH*DATA_W   registered channel outputs, packed like data_in
//  out_valid  out  1               out_data holds a valid operand set
//  sel_err    out  1               sticky: an accepted select was >= NUM_IN
//  hold_cnt   out  HOLD_CNT_W      consecutive stalled cycles while out_valid=1, saturating
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, sel_err=0, hold_cnt=0. Reset overrides every other input.
//  - Latency: 1 cycle. Values accepted at edge N appear on out_data after edge N.
//  - Per-edge priority: reset > flush > stall > accept > bubble.
//    * flush: out_valid<=0, out_data<=0, hold_cnt<=0. Applies even while stall=1.
//    * stall (no flush): out_data and out_valid hold their values.
//      hold_cnt<=hold_cnt+1 if out_valid=1, saturating at all-ones; otherwise hold_cnt holds.
//    * accept (in_valid=1, stall=0):
//      for every c, out_data[c] <= data_in[sel[c]], or DEFAULT_VAL if sel[c] >= NUM_IN.
//      out_valid<=1, hold_cnt<=0.
//    * bubble (in_valid=0, stall=0): out_valid<=0, out_data<=0, hold_cnt<=0.
//  - sel_err: set on any accept edge where some sel[c] >= NUM_IN. It can only fire when NUM_IN
//    is not a power of 2. It stays set until err_clr or reset.
//    If err_clr and a new error occur on the same edge, the set wins (sel_err=1).
//  - Selects are ignored on stall, flush and bubble edges. They never raise sel_err there.
//  - Channels are fully independent. Two channels may pick the same candidate.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared package fwd_pkg:
//    FWD_SEL_* encodings (0=REGFILE, 1=EX_MEM, 2=MEM_WB, 3=IMM);
//    default DATA_W and NUM_IN constants; a typedef for the select field.
//  - One sub-module, mux_n_to_1 (params DATA_W, NUM_IN): combinational selector with a
//    range-error flag. Instantiated NUM_CH times in a generate loop.
//  - Top level: output register, valid/flush/stall control, sel_err flop, hold counter.
// TESTING
//  1 Accept: NUM_IN=4, data_in={D,C,B,A}=32'hDDDD_DDDD..32'hAAAA_AAAA, sel={ch1=2,ch0=1},
//    in_valid=1 -> next cycle out_data ch0=32'hBBBB_BBBB, ch1=32'hCCCC_CCCC, out_valid=1.
//  2 Stall hold: after test 1, stall=1 for 3 cycles while data_in changes -> out_data unchanged,
//    hold_cnt=1,2,3. Release -> new data captured, hold_cnt=0.
//  3 Flush over stall: stall=1 and flush=1 together -> out_valid=0, out_data=0, hold_cnt=0.
//  4 Range error: NUM_IN=3, sel ch0=3 accepted -> ch0=DEFAULT_VAL, sel_err=1.
//    Then err_clr=1 on an edge with a good select -> sel_err=0. err_clr=1 on an edge with a
//    bad select -> sel_err stays 1.
//  5 Saturation and reset: HOLD_CNT_W=2, stall for 5 cycles -> hold_cnt sticks at 3.
//    Assert reset mid-stall -> every output returns to 0 on the next edge.
//  6 Bubble: in_valid=0, stall=0 with valid output present -> out_valid=0, out_data=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared forwarding definitions: select encodings, default sizing and the select field type.
package fwd_pkg;

  localparam int unsigned FWD_DATA_W = 32;
  localparam int unsigned FWD_NUM_IN = 4;
  localparam int unsigned FWD_SEL_W  = $clog2(FWD_NUM_IN);

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_SEL_REGFILE = 2'd0,
    FWD_SEL_EX_MEM  = 2'd1,
    FWD_SEL_MEM_WB  = 2'd2,
    FWD_SEL_IMM     = 2'd3
  } fwd_sel_e;

  // A select field is only unable to reach an illegal code when NUM_IN is a power of two.
  function automatic logic sel_can_overflow(input int unsigned num_in);
    return (num_in & (num_in - 1)) != 0;
  endfunction

endpackage

// File: rtl/fwd_operand_select_if.sv
// Operand-select bus: candidates, selects and hazard controls in, registered operands out.
interface fwd_operand_select_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned HOLD_CNT_W = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic                     in_valid;
  logic                     stall;
  logic                     flush;
  logic                     err_clr;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic [NUM_CH*SEL_W-1:0]  sel;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     sel_err;
  logic [HOLD_CNT_W-1:0]    hold_cnt;

  modport master (
    output in_valid, stall, flush, err_clr, data_in, sel,
    input  out_data, out_valid, sel_err, hold_cnt
  );

  modport slave (
    input  in_valid, stall, flush, err_clr, data_in, sel,
    output out_data, out_valid, sel_err, hold_cnt
  );
endinterface

// File: rtl/mux_n_to_1.sv
// Combinational N:1 selector; out-of-range selects yield DEFAULT_VAL and raise range_err_c.
module mux_n_to_1
  import fwd_pkg::*;
#(
  parameter int unsigned          DATA_W      = FWD_DATA_W,
  parameter int unsigned          NUM_IN      = FWD_NUM_IN,
  parameter logic [DATA_W-1:0]    DEFAULT_VAL = '0,
  localparam int unsigned         SEL_W       = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        data_out_c,
  output logic                     range_err_c
);

  always_comb begin
    data_out_c  = DEFAULT_VAL;
    range_err_c = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data_out_c  = data_in[k*DATA_W +: DATA_W];
        range_err_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fwd_operand_select.sv
// ID/EX operand selector: per-channel N:1 muxes feeding a registered stage with
// flush/stall handling, sticky select-range error and a saturating stall counter.
module fwd_operand_select
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W      = FWD_DATA_W,
  parameter int unsigned NUM_IN      = FWD_NUM_IN,
  parameter int unsigned NUM_CH      = 2,
  parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000,
  parameter int unsigned HOLD_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fwd_operand_select_if.slave  bus
);

  localparam int unsigned           SEL_W      = $clog2(NUM_IN);
  localparam logic [DATA_W-1:0]     DEFAULT_RS = DATA_W'(DEFAULT_VAL);
  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX   = '1;

  logic [NUM_CH*DATA_W-1:0] mux_data_c;
  logic [NUM_CH-1:0]        mux_err_c;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mux_n_to_1 #(
      .DATA_W      (DATA_W),
      .NUM_IN      (NUM_IN),
      .DEFAULT_VAL (DEFAULT_RS)
    ) u_mux (
      .data_in     (bus.data_in),
      .sel         (bus.sel[c*SEL_W +: SEL_W]),
      .data_out_c  (mux_data_c[c*DATA_W +: DATA_W]),
      .range_err_c (mux_err_c[c])
    );
  end

  logic [NUM_CH*DATA_W-1:0] out_data_q,  out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sel_err_q,   sel_err_d;
  logic [HOLD_CNT_W-1:0]    hold_cnt_q,  hold_cnt_d;

  // Edge priority: flush > stall > accept > bubble; a fresh error beats err_clr.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    hold_cnt_d  = hold_cnt_q;
    sel_err_d   = sel_err_q & ~bus.err_clr;

    if (bus.flush) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      hold_cnt_d  = '0;
    end else if (bus.stall) begin
      if (out_valid_q && (hold_cnt_q != HOLD_MAX)) begin
        hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
      end
    end else if (bus.in_valid) begin
      out_data_d  = mux_data_c;
      out_valid_d = 1'b1;
      hold_cnt_d  = '0;
      if (|mux_err_c) begin
        sel_err_d = 1'b1;
      end
    end else begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      hold_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_fwd_operand_select.sv
// Directed bench for fwd_operand_select: two instances (4-input/8-bit counter and
// 3-input/2-bit counter) checked cycle by cycle against a reference model scoreboard.
module tb_fwd_operand_select;
  import fwd_pkg::*;

  localparam logic [31:0] DEF_B = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [63:0] data;
    logic        valid;
    logic        err;
    logic [7:0]  hold;
  } exp_t;

  typedef struct packed {
    logic         rst;
    logic         iv;
    logic         st;
    logic         fl;
    logic         clr;
    logic [127:0] din;
    logic [3:0]   sel;
  } stim_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  fwd_operand_select_if #(.DATA_W(32), .NUM_IN(4), .NUM_CH(2), .HOLD_CNT_W(8)) if_a ();
  fwd_operand_select_if #(.DATA_W(32), .NUM_IN(3), .NUM_CH(2), .HOLD_CNT_W(2)) if_b ();

  fwd_operand_select #(.DATA_W(32), .NUM_IN(4), .NUM_CH(2), .HOLD_CNT_W(8)) dut_a (
    .clk (clk), .reset (rst_a), .bus (if_a)
  );
  fwd_operand_select #(.DATA_W(32), .NUM_IN(3), .NUM_CH(2), .DEFAULT_VAL(DEF_B),
                       .HOLD_CNT_W(2)) dut_b (
    .clk (clk), .reset (rst_b), .bus (if_b)
  );

  exp_t  q_a[$], q_b[$];
  exp_t  m_a, m_b;
  stim_t sa, sb;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;

  function automatic stim_t mk(input logic rst, iv, st, fl, clr,
                               input logic [127:0] din, input logic [3:0] sel);
    stim_t s;
    s.rst = rst; s.iv = iv; s.st = st; s.fl = fl; s.clr = clr; s.din = din; s.sel = sel;
    return s;
  endfunction

  // Reference behaviour of one edge, written from the operand-selector contract.
  function automatic exp_t model_next(input exp_t cur, input stim_t s, input int unsigned nin,
                                      input logic [31:0] dflt, input logic [7:0] hmax);
    exp_t n;
    n = cur;
    if (s.rst) return '0;
    if (s.clr) n.err = 1'b0;
    if (s.fl) begin
      n.data = '0; n.valid = 1'b0; n.hold = '0;
    end else if (s.st) begin
      if (cur.valid && cur.hold < hmax) n.hold = cur.hold + 8'd1;
    end else if (s.iv) begin
      for (int c = 0; c < 2; c++) begin
        int unsigned k;
        k = 32'(s.sel[c*2 +: 2]);
        if (k < nin) n.data[c*32 +: 32] = s.din[k*32 +: 32];
        else begin
          n.data[c*32 +: 32] = dflt;
          n.err = 1'b1;
        end
      end
      n.valid = 1'b1; n.hold = '0;
    end else begin
      n.data = '0; n.valid = 1'b0; n.hold = '0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge on both DUTs, queue the model's expectation, then compare after the edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    rst_a = sa.rst; if_a.in_valid = sa.iv; if_a.stall = sa.st; if_a.flush = sa.fl;
    if_a.err_clr = sa.clr; if_a.data_in = sa.din; if_a.sel = sa.sel;
    rst_b = sb.rst; if_b.in_valid = sb.iv; if_b.stall = sb.st; if_b.flush = sb.fl;
    if_b.err_clr = sb.clr; if_b.data_in = sb.din[95:0]; if_b.sel = sb.sel;
    m_a = model_next(m_a, sa, 4, 32'h0, 8'd255);
    q_a.push_back(m_a);
    m_b = model_next(m_b, sb, 3, DEF_B, 8'd3);
    q_b.push_back(m_b);
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    chk("a_data",  128'(if_a.out_data),  128'(e.data));
    chk("a_valid", 128'(if_a.out_valid), 128'(e.valid));
    chk("a_err",   128'(if_a.sel_err),   128'(e.err));
    chk("a_hold",  128'(if_a.hold_cnt),  128'(e.hold));
    e = q_b.pop_front();
    chk("b_data",  128'(if_b.out_data),  128'(e.data));
    chk("b_valid", 128'(if_b.out_valid), 128'(e.valid));
    chk("b_err",   128'(if_b.sel_err),   128'(e.err));
    chk("b_hold",  128'({6'b0, if_b.hold_cnt}), 128'(e.hold));
  endtask

  logic [127:0] d_abcd, d_1234, d_5678;
  logic [3:0]   sel_21, sel_03, sel_11, sel_23, sel_10;

  initial begin
    d_abcd = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    d_1234 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    d_5678 = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};
    sel_21 = {FWD_SEL_MEM_WB, FWD_SEL_EX_MEM};
    sel_03 = {FWD_SEL_REGFILE, FWD_SEL_IMM};
    sel_11 = {FWD_SEL_EX_MEM, FWD_SEL_EX_MEM};
    sel_23 = {2'd2, 2'd3};
    sel_10 = {2'd1, 2'd0};
    m_a = '0; m_b = '0;

    // Reset both instances, including reset overriding an accept.
    sa = mk(1, 1, 0, 0, 0, d_abcd, sel_21); sb = mk(1, 1, 0, 0, 0, d_abcd, sel_23);
    step();
    chk("reset_valid", 128'(if_a.out_valid), 128'(0));
    sb = mk(0, 0, 0, 0, 0, '0, '0);

    // Accept: ch0 <- B, ch1 <- C.
    sa = mk(0, 1, 0, 0, 0, d_abcd, sel_21); step();
    chk("t1_ch0", 128'(if_a.out_data[31:0]),  128'(32'hBBBB_BBBB));
    chk("t1_ch1", 128'(if_a.out_data[63:32]), 128'(32'hCCCC_CCCC));

    // Stall three cycles while candidates change; then release and capture.
    sa = mk(0, 1, 1, 0, 0, d_1234, sel_21);
    for (int i = 0; i < 3; i++) step();
    chk("t2_hold3", 128'(if_a.hold_cnt), 128'(3));
    chk("t2_ch0_held", 128'(if_a.out_data[31:0]), 128'(32'hBBBB_BBBB));
    sa = mk(0, 1, 0, 0, 0, d_5678, sel_03); step();
    chk("t2_release_ch0", 128'(if_a.out_data[31:0]), 128'(32'h8888_8888));
    sa = mk(0, 1, 0, 0, 0, d_1234, sel_11); step();

    // Stall then flush-over-stall.
    sa = mk(0, 1, 1, 0, 0, d_abcd, sel_21); step();
    sa = mk(0, 1, 1, 1, 0, d_abcd, sel_21); step();
    chk("t3_flush_data", 128'(if_a.out_data), 128'(0));
    sa = mk(0, 0, 1, 0, 0, d_abcd, sel_21); step();
    sa = mk(0, 1, 0, 1, 0, d_abcd, sel_21); step();

    // Bubble after a valid accept.
    sa = mk(0, 1, 0, 0, 0, d_5678, sel_21); step();
    sa = mk(0, 0, 0, 0, 0, d_5678, sel_21); step();
    chk("t6_bubble_valid", 128'(if_a.out_valid), 128'(0));

    // Range error on the 3-input instance and err_clr interaction.
    sa = mk(0, 0, 0, 0, 0, '0, '0);
    sb = mk(0, 1, 0, 0, 0, d_abcd, sel_23); step();
    chk("t4_default", 128'(if_b.out_data[31:0]), 128'(DEF_B));
    chk("t4_err_set", 128'(if_b.sel_err), 128'(1));
    sb = mk(0, 0, 1, 0, 0, d_abcd, sel_10); step();
    sb = mk(0, 1, 0, 0, 1, d_1234, sel_10); step();
    chk("t4_err_clr", 128'(if_b.sel_err), 128'(0));
    sb = mk(0, 1, 0, 0, 1, d_1234, sel_23); step();
    chk("t4_set_wins", 128'(if_b.sel_err), 128'(1));
    sb = mk(0, 0, 0, 0, 1, d_1234, sel_10); step();
    sb = mk(0, 1, 1, 0, 0, d_1234, sel_23); step();
    sb = mk(0, 1, 0, 1, 0, d_1234, sel_23); step();
    sb = mk(0, 0, 0, 0, 0, d_1234, sel_23); step();
    chk("t4_no_err_idle", 128'(if_b.sel_err), 128'(0));

    // Counter saturation at 3, then reset mid-stall.
    sb = mk(0, 1, 0, 0, 0, d_5678, sel_10); step();
    sb = mk(0, 1, 1, 0, 0, d_abcd, sel_23);
    for (int i = 0; i < 5; i++) step();
    chk("t5_sat", 128'(if_b.hold_cnt), 128'(3));
    sb = mk(1, 1, 1, 0, 0, d_abcd, sel_23); step();
    chk("t5_reset_data", 128'(if_b.out_data), 128'(0));
    sb = mk(0, 0, 0, 0, 0, '0, '0); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
